fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, the
// all-zero halt instruction and the fetch FSM state encoding.
package riscv_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;
    localparam int BUS_W   = 64;

    localparam logic [INSTR_W-1:0] ZERO_INSTR = '0;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one aligned 64-bit read at a
// time, selects the 32-bit instruction word and hands it to decode together
// with its next-PC. Later stages may redirect the PC at any time; fetching
// stops on the all-zero instruction until a redirect or reset.
//
// Handshakes: the memory request transfers on a rising edge where
// mem_req_valid and mem_req_ready are both 1; while valid is high and ready
// is low the address is held. Exactly one mem_resp_valid pulse is returned
// per transferred request, in order. Decode takes instr_reg/IFID_npc on a
// rising edge where IFID_ready=1 and stall=0; redirect_valid overrides that
// transfer and squashes the held instruction.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter bit              HALT_ON_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               mem_req_valid,
    output logic [XLEN-1:0]    mem_req_addr,
    input  logic               mem_req_ready,
    input  logic               mem_resp_valid,
    input  logic [BUS_W-1:0]   mem_resp_data,
    output logic [INSTR_W-1:0] instr_reg,
    output logic [XLEN-1:0]    IFID_npc,
    output logic               IFID_ready,
    output logic               halted,
    output fetch_state_e       dbg_state
);

    fetch_state_e        state;
    logic [XLEN-1:0]     pc;
    logic                drop;
    logic [INSTR_W-1:0]  word;
    logic [XLEN-1:0]     pc_plus4;

    // Word select, next sequential PC and the combinational request port.
    // The request is suppressed during the reset cycle whatever the state.
    always_comb begin
        word          = pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
        pc_plus4      = pc + 64'd4;
        mem_req_valid = (state == S_REQ) && !reset;
        mem_req_addr  = {pc[XLEN-1:3], 3'b000};
        dbg_state     = state;
    end

    // Fetch FSM with registered IF/ID outputs; redirect outranks everything
    // except reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            instr_reg  <= '0;
            IFID_npc   <= '0;
            IFID_ready <= 1'b0;
            halted     <= 1'b0;
        end else if (redirect_valid) begin
            pc         <= redirect_pc & ~64'd3;
            IFID_ready <= 1'b0;
            halted     <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        // The in-flight response is stale; nothing else outstanding.
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        // Response still owed by memory; swallow it when it arrives.
                        drop  <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        // Old-address request transfers on this edge; discard its data.
                        drop  <= 1'b1;
                        state <= S_WAIT;
                    end else begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            instr_reg  <= word;
                            IFID_npc   <= pc_plus4;
                            IFID_ready <= 1'b1;
                            pc         <= pc_plus4;
                            if (HALT_ON_ZERO && (word == ZERO_INSTR)) begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                state  <= S_OUT;
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (!stall) begin
                        IFID_ready <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_HALT: begin
                    if (!stall) begin
                        IFID_ready <= 1'b0;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural instruction memory with programmable
// response delay and ready hold-off, a decode-side consumer that compares
// every accepted instruction against an expected queue, and a request
// monitor that compares request addresses against a second queue.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [63:0]  redirect_pc = '0;
    logic         mem_req_valid;
    logic [63:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_resp_valid = 1'b0;
    logic [63:0]  mem_resp_data = '0;
    logic [31:0]  instr_reg;
    logic [63:0]  IFID_npc;
    logic         IFID_ready;
    logic         halted;
    fetch_state_e dbg_state;

    fetch_stage #(.RESET_PC(64'h0), .HALT_ON_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .instr_reg(instr_reg),
        .IFID_npc(IFID_npc), .IFID_ready(IFID_ready), .halted(halted),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int consumed = 0;
    int req_count = 0;
    logic [95:0] exp_q[$];       // {instr, npc}
    logic [63:0] exp_addr_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic        hold_ready = 1'b0;
    int          resp_delay = 0;
    logic        flush = 1'b0;
    logic        accepted = 1'b0;
    logic [63:0] acc_addr = '0;
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [63:0] pend_addr = '0;

    assign mem_req_ready = !hold_ready;

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        if (a == 64'h0)        return 64'h00500093_00000013;
        else if (a == 64'h300) return 64'h0;
        else                   return {a[31:0] | 32'h8000_0001, a[31:0] | 32'h4000_0003};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (flush) begin
                pending  = 1'b0;
                accepted = 1'b0;
                flush    = 1'b0;
            end
            if (accepted) begin
                pending   = 1'b1;
                cnt       = resp_delay;
                pend_addr = acc_addr;
                accepted  = 1'b0;
            end
            if (pending) begin
                if (cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_data(pend_addr);
                    pending        = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Request monitor: handshakes are seen at negedge and complete at the next posedge.
    always @(negedge clk) begin
        if (!reset && mem_req_valid && mem_req_ready) begin
            accepted = 1'b1;
            acc_addr = mem_req_addr;
            req_count++;
            if (!redirect_valid && exp_addr_q.size() > 0)
                check("mem_req_addr", mem_req_addr, exp_addr_q.pop_front());
        end
        if (!reset && mem_resp_valid)
            check("resp_only_in_wait", 64'(dbg_state == S_WAIT), 64'd1);
    end

    // Decode-side consumer.
    always @(negedge clk) begin
        logic [95:0] e;
        if (!reset && IFID_ready && !stall && !redirect_valid) begin
            consumed++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_consume: instr %h npc %h, required none", instr_reg, IFID_npc);
            end else begin
                e = exp_q.pop_front();
                check("instr_reg", 64'(instr_reg), 64'(e[95:64]));
                check("IFID_npc", IFID_npc, e[63:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_consumed(input int target);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (consumed >= target) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_consumed: got %0d consumed, required %0d", consumed, target);
    endtask

    task automatic wait_state(input fetch_state_e st);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dbg_state == st) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_state: state %0d, required %0d", dbg_state, st);
    endtask

    task automatic redirect_to(input logic [63:0] a);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = a;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic stall_now();
        @(posedge clk); #1;
        stall = 1'b1;
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [63:0] addr;
        logic [31:0] instr;
        logic [63:0] npc;
        int          delay;
    } vec_t;

    vec_t vecs[5];

    // ---------------- main sequence ----------------
    initial begin
        int snap;
        vecs[0] = '{64'h1004, 64'h1000, 32'h8000_1001, 64'h1008, 0};
        vecs[1] = '{64'h203, 64'h200, 32'h4000_0203, 64'h204, 2};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF9, 64'h0, 1};
        vecs[3] = '{64'h2A8, 64'h2A8, 32'h4000_02AB, 64'h2AC, 0};
        vecs[4] = '{64'h7_0000_0010, 64'h7_0000_0010, 32'h4000_0013, 64'h7_0000_0014, 3};

        // Reset and reset-cycle values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_instr_reg", 64'(instr_reg), 64'd0);
        check("rst_IFID_npc", IFID_npc, 64'd0);
        check("rst_IFID_ready", 64'(IFID_ready), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);

        // Two fetches out of the first doubleword.
        exp_addr_q.push_back(64'h0);
        exp_addr_q.push_back(64'h0);
        exp_q.push_back({32'h0000_0013, 64'h4});
        exp_q.push_back({32'h0050_0093, 64'h8});
        @(posedge clk); #1;
        reset = 1'b0;
        wait_consumed(2);
        stall_now();

        // Stall holds the third instruction (pc 8) in place.
        wait_state(S_OUT);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_instr", 64'(instr_reg), 64'h4000_000B);
            check("stall_npc", IFID_npc, 64'hC);
            check("stall_ready", 64'(IFID_ready), 64'd1);
            check("stall_no_req", 64'(mem_req_valid), 64'd0);
        end
        exp_q.push_back({32'h4000_000B, 64'hC});
        @(posedge clk); #1;
        stall = 1'b0;
        wait_consumed(3);
        check("stall_release_no_req", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        check("req_after_stall", 64'(mem_req_valid), 64'd1);
        stall = 1'b1;

        // Table of redirect targets, each delivered once.
        for (int v = 0; v < 5; v++) begin
            wait_state(S_OUT);
            resp_delay = vecs[v].delay;
            exp_addr_q.push_back(vecs[v].addr);
            exp_q.push_back({vecs[v].instr, vecs[v].npc});
            redirect_to(vecs[v].pc);
            stall = 1'b0;
            wait_consumed(consumed + 1);
            stall_now();
        end
        resp_delay = 0;

        // Redirect while a slow response is outstanding.
        wait_state(S_OUT);
        resp_delay = 3;
        exp_addr_q.push_back(64'h2000);
        exp_addr_q.push_back(64'h1000);
        exp_q.push_back({32'h8000_1001, 64'h1008});
        redirect_to(64'h2000);
        wait_state(S_WAIT);
        resp_delay = 0;
        redirect_to(64'h1004);
        stall = 1'b0;
        wait_consumed(consumed + 1);
        stall_now();
        check("stale_drained", 64'(exp_addr_q.size()), 64'd0);

        // Memory holds ready low for 4 cycles.
        wait_state(S_OUT);
        hold_ready = 1'b1;
        exp_addr_q.push_back(64'h3000);
        exp_q.push_back({32'h4000_3003, 64'h3004});
        snap = req_count;
        redirect_to(64'h3000);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(mem_req_valid), 64'd1);
            check("hold_addr", mem_req_addr, 64'h3000);
        end
        @(posedge clk); #1;
        hold_ready = 1'b0;
        wait_consumed(consumed + 1);
        check("hold_one_request", 64'(req_count - snap), 64'd1);
        stall_now();

        // Zero instruction halts fetch; redirect restarts it.
        wait_state(S_OUT);
        exp_addr_q.push_back(64'h300);
        exp_q.push_back({32'h0, 64'h304});
        redirect_to(64'h300);
        stall = 1'b0;
        wait_consumed(consumed + 1);
        snap = req_count;
        repeat (20) @(negedge clk);
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_ready_dropped", 64'(IFID_ready), 64'd0);
        check("halt_no_requests", 64'(req_count - snap), 64'd0);
        exp_addr_q.push_back(64'h200);
        exp_q.push_back({32'h4000_0203, 64'h204});
        redirect_to(64'h200);
        @(negedge clk);
        check("unhalt_halted", 64'(halted), 64'd0);
        check("unhalt_req_valid", 64'(mem_req_valid), 64'd1);
        wait_consumed(consumed + 1);
        stall_now();

        // Reset in the middle of a wait restarts at RESET_PC.
        wait_state(S_OUT);
        resp_delay = 10;
        redirect_to(64'h5000);
        wait_state(S_WAIT);
        @(posedge clk); #1;
        reset = 1'b1;
        flush = 1'b1;
        stall = 1'b0;
        exp_addr_q.push_back(64'h0);
        exp_q.push_back({32'h0000_0013, 64'h4});
        @(negedge clk);
        check("midrst_req_valid", 64'(mem_req_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        resp_delay = 0;
        @(negedge clk);
        check("midrst_instr", 64'(instr_reg), 64'd0);
        check("midrst_npc", IFID_npc, 64'd0);
        check("midrst_ready", 64'(IFID_ready), 64'd0);
        check("midrst_halted", 64'(halted), 64'd0);
        check("midrst_req_addr", mem_req_addr, 64'h0);
        wait_consumed(consumed + 1);
        stall_now();

        repeat (10) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("exp_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
